// File: rtl/udp_rx_word_packer.sv
// -----------------------------------------------------------------------------
// udp_rx_word_packer
//
// Packs the UDP receive byte stream into big-endian 32-bit words with
// keep/last/err qualifiers and buffers them in a small output FIFO.
//
// Ports
//   gmii_rx_clk          : clock, rising edge
//   rst_n                : asynchronous active-low reset
//   udp_rec_ram_read_en  : byte read strobe (data follows one cycle later)
//   udp_rec_ram_rdata    : byte data
//   udp_rec_data_length  : UDP length incl. 8-byte header, sampled at start
//   word_data/keep/last/err/valid : registered FIFO head
//   word_ready           : consumer accept
//   pause                : occupancy >= FIFO_DEPTH-2 (registered, lags 1 cycle)
//   overflow             : sticky, a word was discarded on a full FIFO
//   pkt_count            : completed packets (wraps)
//   drop_count           : discarded packets (saturates)
// -----------------------------------------------------------------------------
module udp_rx_word_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_LEN    = 1472,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        udp_rec_ram_read_en,
  input  logic [7:0]  udp_rec_ram_rdata,
  input  logic [15:0] udp_rec_data_length,
  output logic [31:0] word_data,
  output logic [3:0]  word_keep,
  output logic        word_last,
  output logic        word_err,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        pause,
  output logic        overflow,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = 38;  // {data[31:0], keep[3:0], last, err}

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PAUSE_CNT = CW'(FIFO_DEPTH - 2);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [15:0]   MAX_LEN_C = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DROP    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            bv_q;
  logic [15:0]     rem_q, rem_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     shreg_q, shreg_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   head_q, head_d;
  logic            valid_q, pause_q, overflow_q;
  logic [15:0]     pkt_cnt_q, drop_cnt_q;

  logic [15:0]     pay_len_s;
  logic [31:0]     lane_s;
  logic [3:0]      keep_s, keep_fill_s;
  logic            push_req_s, push_ok_s, pop_s, fifo_room_s;
  logic [EW-1:0]   push_word_s;
  logic            cnt_pkt_s, cnt_drop_s;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign pop_s       = word_ready & valid_q;
  assign fifo_room_s = (count_q != FULL_CNT) | pop_s;
  assign push_ok_s   = push_req_s & fifo_room_s;

  // Packing state machine: next-state, lane insertion and push request.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    to_cnt_d    = to_cnt_q;
    push_req_s  = 1'b0;
    push_word_s = '0;
    cnt_pkt_s   = 1'b0;
    cnt_drop_s  = 1'b0;
    pay_len_s   = udp_rec_data_length - 16'd8;
    lane_s      = shreg_q | ({udp_rec_ram_rdata, 24'h000000} >> {idx_q, 3'b000});
    keep_s      = 4'b1111 << (2'd3 - idx_q);
    keep_fill_s = ~(4'b1111 >> idx_q);
    case (state_q)
      S_IDLE: begin
        if (udp_rec_ram_read_en) begin
          rem_d    = pay_len_s;
          idx_d    = 2'd0;
          shreg_d  = 32'h0000_0000;
          to_cnt_d = '0;
          if ((udp_rec_data_length <= 16'd8) || (pay_len_s > MAX_LEN_C)) begin
            state_d    = S_DROP;
            cnt_drop_s = 1'b1;
            // Nothing meaningful to count down for an empty/short datagram.
            if (udp_rec_data_length <= 16'd8) begin
              rem_d = 16'd0;
            end else begin
              rem_d = pay_len_s;
            end
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (bv_q) begin
          to_cnt_d = '0;
          rem_d    = rem_q - 16'd1;
          if ((idx_q == 2'd3) || (rem_q == 16'd1)) begin
            push_req_s  = 1'b1;
            push_word_s = {lane_s, keep_s, (rem_q == 16'd1), 1'b0};
            shreg_d     = 32'h0000_0000;
            idx_d       = 2'd0;
            if (!fifo_room_s) begin
              state_d    = S_DROP;
              cnt_drop_s = 1'b1;
            end else if (rem_q == 16'd1) begin
              state_d   = S_IDLE;
              cnt_pkt_s = 1'b1;
            end else begin
              state_d = S_COLLECT;
            end
          end else begin
            shreg_d = lane_s;
            idx_d   = idx_q + 2'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Stalled mid-packet: flush what we have (possibly nothing) as errored last.
          push_req_s  = 1'b1;
          push_word_s = {shreg_q, keep_fill_s, 1'b1, 1'b1};
          shreg_d     = 32'h0000_0000;
          idx_d       = 2'd0;
          to_cnt_d    = '0;
          state_d     = S_IDLE;
          cnt_drop_s  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DROP: begin
        if (rem_q == 16'd0) begin
          state_d = S_IDLE;
        end else if (bv_q) begin
          to_cnt_d = '0;
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DROP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO next pointers, occupancy and the next registered head word.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    count_d  = count_q + CW'(push_ok_s) - CW'(pop_s);
    head_d   = '0;
    if (count_d != '0) begin
      // Bypass when the pushed word becomes the head in this same cycle.
      if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_word_s;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end else begin
      head_d = '0;
    end
  end

  // All state: FSM, byte-valid pipe, FIFO storage, outputs and counters.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bv_q       <= 1'b0;
      rem_q      <= 16'd0;
      idx_q      <= 2'd0;
      shreg_q    <= 32'h0000_0000;
      to_cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      pause_q    <= 1'b0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      bv_q     <= udp_rec_ram_read_en;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      to_cnt_q <= to_cnt_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_word_s;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      pause_q  <= (count_q >= PAUSE_CNT);
      if (push_req_s && !fifo_room_s) begin
        overflow_q <= 1'b1;
      end
      if (cnt_pkt_s) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (cnt_drop_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign word_data  = head_q[37:6];
  assign word_keep  = head_q[5:2];
  assign word_last  = head_q[1];
  assign word_err   = head_q[0];
  assign word_valid = valid_q;
  assign pause      = pause_q;
  assign overflow   = overflow_q;
  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule
